seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 89 ++++++++
 tb/tb_seq_multiplier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one partial product per clock, start/done handshake.
// Latency WIDTH cycles; optional early termination under SEQ_MULT_EARLY_TERM_EN. start ignored while busy.
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               in_ready,
   output logic               busy,
   output logic               done,
   output logic               res_valid,
   output logic [2*WIDTH-1:0] res
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    acc_nxt;
   logic [WIDTH-1:0] mult;
   logic [WIDTH-1:0] mult_nxt;
   logic [CW-1:0]    count;
   logic             last;

   assign acc_nxt  = mult[0] ? acc + mcand : acc;
   assign mult_nxt = mult >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
   // Stop as soon as no multiplier bits remain; the count exit still bounds the run.
   assign last = (count == LAST) || (mult_nxt == '0);
`else
   assign last = (count == LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mult      <= '0;
         count     <= '0;
         res       <= '0;
         res_valid <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand     <= {{WIDTH{1'b0}}, a};
                  mult      <= b;
                  acc       <= '0;
                  count     <= '0;
                  state     <= RUN;
                  busy      <= 1'b1;
                  in_ready  <= 1'b0;
                  res_valid <= 1'b0;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               mcand <= mcand << 1;
               mult  <= mult_nxt;
               count <= count + CW'(1);
               if (last) begin
                  state     <= DONE;
                  res       <= acc_nxt;
                  done      <= 1'b1;
                  res_valid <= 1'b1;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        in_ready4, busy4, done4, res_valid4;
   logic [7:0]  res4;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        in_ready8, busy8, done8, res_valid8;
   logic [15:0] res8;

   typedef struct {
      logic [15:0] res;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   seq_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .in_ready(in_ready4), .busy(busy4), .done(done4), .res_valid(res_valid4), .res(res4)
   );

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .in_ready(in_ready8), .busy(busy8), .done(done8), .res_valid(res_valid8), .res(res8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic int lat8(input logic [7:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
      int l = 1;
      for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
      return l;
`else
      return 8;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop the oldest expectation and compare against the completed product.
   task automatic score(input string tag, input logic [15:0] got, input int cyc);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 0, 1);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, "_res"}, got, e.res);
      chk({tag, "_lat"}, cyc, e.lat);
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit detail);
      exp_t e;
      int   cyc;
      start4 = 1'b1; a4 = a; b4 = b;
      tick();
      start4 = 1'b0;
      e.res = 16'(a * b); e.lat = 4;
      exp_q.push_back(e);
      if (detail) begin
         chk("w4_busy", busy4, 1);
         chk("w4_in_ready_run", in_ready4, 0);
         chk("w4_res_valid_run", res_valid4, 0);
      end
      cyc = 0;
      while (!done4 && cyc < 20) begin
         tick();
         cyc++;
      end
      score("w4", {8'h00, res4}, cyc);
      if (detail) begin
         chk("w4_res_valid", res_valid4, 1);
         tick();
         chk("w4_done_pulse", done4, 0);
         chk("w4_res_hold", res4, 8'(a * b));
      end else begin
         tick();
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   cyc;
      start8 = 1'b1; a8 = a; b8 = b;
      tick();
      start8 = 1'b0;
      e.res = 16'(a) * 16'(b); e.lat = lat8(b);
      exp_q.push_back(e);
      cyc = 0;
      while (!done8 && cyc < 30) begin
         tick();
         cyc++;
      end
      score("w8", res8, cyc);
      tick();
   endtask

   initial begin
      exp_t e;
      int   cyc;
      int   ndone;

      // Reset state
      #12;
      chk("rst_res", res4, 0);
      chk("rst_res_valid", res_valid4, 0);
      chk("rst_done", done4, 0);
      chk("rst_busy", busy4, 0);
      chk("rst_in_ready", in_ready4, 1);
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_in_ready", in_ready4, 1);
      chk("idle_res_valid8", res_valid8, 0);

      // Asynchronous reset in the middle of a run
      start4 = 1'b1; a4 = 4'd9; b4 = 4'd7;
      tick();
      start4 = 1'b0;
      tick();
      chk("mid_busy", busy4, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy4, 0);
      chk("arst_in_ready", in_ready4, 1);
      chk("arst_res", res4, 0);
      chk("arst_res_valid", res_valid4, 0);
      chk("arst_done", done4, 0);
      #10 rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done4) ndone++;
      end
      chk("arst_no_done", ndone, 0);

      // Exhaustive WIDTH=4
      run4(4'd15, 4'd15, 1'b1);
      run4(4'd0, 4'd13, 1'b1);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run4(4'(i), 4'(j), 1'b0);

      // start while busy is ignored
      start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
      tick();
      e.res = 16'd15; e.lat = 4;
      exp_q.push_back(e);
      a4 = 4'd15; b4 = 4'd15;
      cyc = 0;
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", in_ready4, 0);
         tick();
         cyc++;
      end
      start4 = 1'b0;
      while (!done4 && cyc < 20) begin
         tick();
         cyc++;
      end
      score("bp", {8'h00, res4}, cyc);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done4) ndone++;
      end
      chk("bp_no_second_done", ndone, 0);
      chk("bp_res_hold", res4, 15);

      // Back-to-back with start held high
      start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
      tick();
      e.res = 16'd42; e.lat = 4;
      exp_q.push_back(e);
      a4 = 4'd2; b4 = 4'd11;
      cyc = 0;
      while (!done4 && cyc < 20) begin
         tick();
         cyc++;
      end
      score("b2b1", {8'h00, res4}, cyc);
      chk("b2b1_valid", res_valid4, 1);
      tick();
      start4 = 1'b0;
      e.res = 16'd22; e.lat = 4;
      exp_q.push_back(e);
      cyc = 0;
      while (!done4 && cyc < 20) begin
         chk("b2b_gap_valid", res_valid4, 0);
         chk("b2b_gap_res", res4, 42);
         tick();
         cyc++;
      end
      score("b2b2", {8'h00, res4}, cyc);
      chk("b2b2_valid", res_valid4, 1);
      tick();

      // WIDTH=8 instance, including early-termination operands
      run8(8'd255, 8'd255);
      run8(8'd128, 8'd2);
      run8(8'd200, 8'd1);
      run8(8'd10, 8'h05);
      run8(8'd3, 8'h80);
      run8(8'd77, 8'd0);
      run8(8'd0, 8'd200);
      for (int i = 0; i < 20; i++)
         run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
